mv_result_drain: RTL
====================

// Module: mv_result_drain
// PURPOSE
//  Read-side companion to mat_vec_mult. When the MAC array signals completion,
//  snapshots all ROWS accumulator outputs in one cycle. Streams them out one
//  row per handshake on a valid/ready port, then pulses clr to zero the array.
//  Sits between mat_vec_mult and the host/result sink. Together with the
//  FIFO-write side, this closes the load -> compute -> drain loop.
// PARAMETERS
//  ROWS        8    number of accumulator rows (matches mat_vec_mult FIFO count)
//  DATA_WIDTH  8    operand width; accumulator width ACC_W = 3*DATA_WIDTH (24)
//  OUT_W       24   streamed data width; OUT_W <= ACC_W
//  IDX_W       3    row index width, $clog2(ROWS)
// PORTS
//  clk        in   1           system clock; all logic on posedge
//  rst_n      in   1           synchronous active-low reset
//  done       in   1           compute-complete from mat_vec_mult, level or pulse
//  acc_in     in   ROWS*ACC_W  flattened accumulators; row r = acc_in[r*ACC_W +: ACC_W]
//  out_valid  out  1           out_data/out_idx/out_last valid
//  out_ready  in   1           sink accepts current word
//  out_data   out  OUT_W       row result, unsigned, saturated to OUT_W
//  out_idx    out  IDX_W       row number of out_data, 0..ROWS-1
//  out_last   out  1           high with the word for row ROWS-1
//  clr        out  1           one-cycle active-high clear to mat_vec_mult
//  busy       out  1           high in any state other than IDLE
//  overrun    out  1           sticky: done rose while not IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - State goes to IDLE.
//   - out_valid, out_data, out_idx, out_last, clr, busy, overrun all 0.
//   - Shadow registers are cleared.
//   - Reset mid-stream abandons the frame and emits no clr.
//  FSM IDLE -> SEND -> CLEAR -> IDLE:
//   - IDLE: done=1 at posedge -> capture all rows into shadow regs, idx<=0, go SEND.
//     out_valid is high the next cycle (1-cycle latency from done).
//   - SEND: out_valid=1, out_data=sat(shadow[idx]), out_idx=idx.
//     out_last = (idx==ROWS-1).
//     On valid&ready, idx advances; if idx==ROWS-1, go CLEAR instead.
//     With out_ready low, outputs hold stable (no change until accepted).
//   - CLEAR: clr=1 for exactly one cycle, out_valid=0, then IDLE.
//  Handshake rules:
//   - out_ready held high gives ROWS words on consecutive cycles.
//   - Whole frame: ROWS+1 cycles after the capture cycle.
//   - out_valid never depends combinationally on out_ready.
//  Capture and edge detection:
//   - Capture uses acc_in sampled on the done cycle only. Later acc_in changes
//     do not affect the frame.
//   - done is edge-detected internally: a level held high re-arms only after
//     it drops. So a held done after CLEAR does not start a second frame.
//  Overrun:
//   - A done rising edge in SEND or CLEAR sets overrun (sticky until rst_n).
//     That edge is otherwise ignored.
//   - A done rising edge in the same cycle the FSM returns to IDLE is taken as
//     a new frame.
//  Saturation:
//   - If OUT_W < ACC_W and shadow[idx] >= 2**OUT_W, out_data = all ones.
//   - Otherwise out_data = shadow[idx][OUT_W-1:0].
//   - OUT_W == ACC_W passes through unchanged.
// TESTING
//  1. Reset with done=1 and acc_in nonzero -> all outputs 0, no capture while
//     rst_n=0.
//  2. acc_in rows = r*100 (0..700), done pulse, out_ready=1 -> out_data
//     0,100..700 on 8 consecutive cycles. idx 0..7, out_last only on 700,
//     clr one cycle after.
//  3. Same frame, out_ready toggled 1,0,0,1... -> data/idx stable while stalled,
//     each row exactly once, no duplicates.
//  4. OUT_W=16, a row = 24'h01_2345 -> out_data 16'hFFFF. Row 24'h00_1234 ->
//     16'h1234.
//  5. done re-pulsed during SEND at idx=3 -> overrun=1 and frame completes
//     unchanged. acc_in changed after capture is not reflected.
//  6. rst_n low at idx=5 -> out_valid=0 next cycle, clr never asserted. A new
//     done then starts at idx 0.

Source files
------------

// File: rtl/mv_result_drain.sv
// Result drain for mat_vec_mult: snapshots every accumulator row on a done edge,
// streams the rows out over valid/ready, then pulses clr to zero the MAC array.
module mv_result_drain #(
    parameter int ROWS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_W      = 24,
    parameter int IDX_W      = $clog2(ROWS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           done,
    input  logic [ROWS*3*DATA_WIDTH-1:0]   acc_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           clr,
    output logic                           busy,
    output logic                           overrun
);

    localparam int ACC_W = 3 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              done_q;
    logic              done_rise;
    logic              capture;
    logic              advance;
    logic [IDX_W-1:0]  idx_q;
    logic              overrun_q;
    logic [ACC_W-1:0]  shadow_p0 [ROWS];

    // Unsigned clamp of an accumulator into the streamed width.
    function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] v);
        logic [ACC_W-1:0] hi;
        hi = v >> OUT_W;
        if (OUT_W < ACC_W && hi != '0)
            return '1;
        return v[OUT_W-1:0];
    endfunction

    assign done_rise = done & ~done_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        advance   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    advance = 1'b1;
                    if (idx_q == LAST_IDX)
                        state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control: edge detector, row pointer, sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= done;
            if (capture)
                idx_q <= '0;
            else if (advance && idx_q != LAST_IDX)
                idx_q <= idx_q + 1'b1;
            if (done_rise && state_q != IDLE)
                overrun_q <= 1'b1;
        end
    end

    // Stage p0: snapshot of all rows, frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                shadow_p0[r] <= '0;
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++)
                shadow_p0[r] <= acc_in[r*ACC_W +: ACC_W];
        end
    end

    assign out_data = out_valid ? sat_out(shadow_p0[idx_q]) : '0;
    assign out_idx  = idx_q;
    assign busy     = (state_q != IDLE);
    assign overrun  = overrun_q;

endmodule
